// File: rtl/decode_regfile.sv
// CPU15 decode stage with 8x16 register file; `DECODE_FWD_EN adds the write-back bypass to operand reads.
// Latency: 1 cycle ROM_DATA -> outputs; write-back commits one edge after execute; no backpressure, never stalls.
module decode_regfile (
    input  logic        CLK_EX,
    input  logic        RESET_N,
    input  logic [14:0] ROM_DATA,
    input  logic [15:0] REG_IN,
    input  logic        REG_WEN,
    output logic [3:0]  OP_CODE,
    output logic [15:0] REG_A,
    output logic [15:0] REG_B,
    output logic [7:0]  OP_DATA,
    output logic [7:0]  RAM_RADDR,
    output logic [7:0]  RAM_WADDR
);

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] ia;
        logic [2:0] ib;
        logic [7:0] imm;
    } instr_t;

    instr_t      ins;
    logic [15:0] rf [8];
    logic [2:0]  dst_d;
    logic [2:0]  dst_w;
    logic [15:0] rd_a;
    logic [15:0] rd_b;

    // ib and imm overlap; both are extracted and execute picks the one it needs
    assign ins = '{op: ROM_DATA[14:11], ia: ROM_DATA[10:8], ib: ROM_DATA[7:5], imm: ROM_DATA[7:0]};

`ifdef DECODE_FWD_EN
    always_comb begin
        rd_a = rf[ins.ia];
        rd_b = rf[ins.ib];
        if (REG_WEN && (dst_w == ins.ia)) rd_a = REG_IN;
        if (REG_WEN && (dst_w == ins.ib)) rd_b = REG_IN;
    end
`else
    assign rd_a = rf[ins.ia];
    assign rd_b = rf[ins.ib];
`endif

    // dst_w trails issue by two edges: it names the register whose result sits on REG_IN
    always_ff @(posedge CLK_EX) begin
        if (!RESET_N) begin
            OP_CODE   <= '0;
            REG_A     <= '0;
            REG_B     <= '0;
            OP_DATA   <= '0;
            RAM_RADDR <= '0;
            RAM_WADDR <= '0;
            dst_d     <= '0;
            dst_w     <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            OP_CODE   <= ins.op;
            REG_A     <= rd_a;
            REG_B     <= rd_b;
            OP_DATA   <= ins.imm;
            RAM_RADDR <= ins.imm;
            RAM_WADDR <= OP_DATA;
            dst_d     <= ins.ia;
            dst_w     <= dst_d;
            if (REG_WEN) rf[dst_w] <= REG_IN;
        end
    end

endmodule

// File: tb/tb_decode_regfile.sv
// Scoreboarded random/directed bench for decode_regfile against an instruction-history reference model.
module tb_decode_regfile;

    logic        CLK_EX = 1'b0;
    logic        RESET_N = 1'b0;
    logic [14:0] ROM_DATA = '0;
    logic [15:0] REG_IN = '0;
    logic        REG_WEN = 1'b0;
    logic [3:0]  OP_CODE;
    logic [15:0] REG_A, REG_B;
    logic [7:0]  OP_DATA, RAM_RADDR, RAM_WADDR;

    decode_regfile dut (
        .CLK_EX(CLK_EX), .RESET_N(RESET_N), .ROM_DATA(ROM_DATA), .REG_IN(REG_IN),
        .REG_WEN(REG_WEN), .OP_CODE(OP_CODE), .REG_A(REG_A), .REG_B(REG_B),
        .OP_DATA(OP_DATA), .RAM_RADDR(RAM_RADDR), .RAM_WADDR(RAM_WADDR)
    );

    always #5 CLK_EX = ~CLK_EX;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  imm;
        logic [7:0]  raddr;
        logic [7:0]  waddr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // reference state: architectural registers plus the destination of every latched instruction
    logic [15:0] m_rf [8];
    logic [2:0]  m_hist [$];
    logic [7:0]  m_prev_imm;

`ifdef DECODE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] m_rd(input logic [2:0] i, input logic wen,
                                         input logic [15:0] din, input logic [2:0] wdst);
        if (FWD && wen && (wdst == i)) return din;
        return m_rf[i];
    endfunction

    // drive one edge worth of inputs and predict what the DUT shows after that edge
    task automatic step(input logic rst, input logic [14:0] rom, input logic wen, input logic [15:0] din);
        exp_t       e;
        logic [2:0] wdst;
        @(negedge CLK_EX);
        RESET_N  = ~rst;
        ROM_DATA = rom;
        REG_WEN  = wen;
        REG_IN   = din;
        if (rst) begin
            e = '0;
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
            m_hist.delete();
            m_hist.push_back(3'd0);
            m_hist.push_back(3'd0);
            m_prev_imm = '0;
        end else begin
            wdst    = m_hist[0];
            e.op    = rom[14:11];
            e.a     = m_rd(rom[10:8], wen, din, wdst);
            e.b     = m_rd(rom[7:5], wen, din, wdst);
            e.imm   = rom[7:0];
            e.raddr = rom[7:0];
            e.waddr = m_prev_imm;
            if (wen) m_rf[wdst] = din;
            m_hist.push_back(rom[10:8]);
            void'(m_hist.pop_front());
            m_prev_imm = rom[7:0];
        end
        sb.push_back(e);
    endtask

    function automatic logic [14:0] mk(input logic [3:0] op, input logic [2:0] ia,
                                       input logic [2:0] ib, input logic [4:0] lo);
        return {op, ia, ib, lo};
    endfunction

    // monitor: one result per edge, compared after outputs settle
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK_EX);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("op_code",   {12'h0, OP_CODE},   {12'h0, e.op});
                chk("reg_a",     REG_A,              e.a);
                chk("reg_b",     REG_B,              e.b);
                chk("op_data",   {8'h0, OP_DATA},    {8'h0, e.imm});
                chk("ram_raddr", {8'h0, RAM_RADDR},  {8'h0, e.raddr});
                chk("ram_waddr", {8'h0, RAM_WADDR},  {8'h0, e.waddr});
            end
        end
    end

    initial begin
        logic [14:0] nop;
        nop = '0;
        // reset held two edges with busy inputs and a write request
        step(1'b1, 15'h7FFF, 1'b1, 16'hA5A5);
        step(1'b1, 15'h7FFF, 1'b1, 16'h5A5A);
        for (int i = 0; i < 8; i++) step(1'b0, mk(4'h2, 3'(i), 3'(i), 5'h00), 1'b0, 16'h0);

        // field split and RAM_WADDR delay
        step(1'b0, mk(4'h1, 3'd2, 3'd5, 5'h0A), 1'b0, 16'h0);
        step(1'b0, nop, 1'b0, 16'h0);

        // LDL r3, then read r3 at distance 2 and 3
        step(1'b0, mk(4'h3, 3'd3, 3'd0, 5'h12), 1'b0, 16'h0);
        step(1'b0, nop, 1'b0, 16'h0);
        step(1'b0, mk(4'h2, 3'd3, 3'd1, 5'h00), 1'b1, 16'h1234);
        step(1'b0, mk(4'h2, 3'd3, 3'd1, 5'h00), 1'b0, 16'h0);

        // write r4 then ADD r4,r4 at distance 2
        step(1'b0, mk(4'h3, 3'd4, 3'd0, 5'h1F), 1'b0, 16'h0);
        step(1'b0, nop, 1'b0, 16'h0);
        step(1'b0, mk(4'h4, 3'd4, 3'd4, 5'h00), 1'b1, 16'h00FF);
        step(1'b0, mk(4'h4, 3'd4, 3'd4, 5'h00), 1'b0, 16'h0);

        // branch bubble: REG_IN garbage with REG_WEN low, then read back all registers
        for (int i = 0; i < 3; i++) step(1'b0, mk(4'hA, 3'(i + 3), 3'd0, 5'h00), 1'b0, 16'hDEAD);
        for (int i = 0; i < 8; i++) step(1'b0, mk(4'h2, 3'(i), 3'(7 - i), 5'h00), 1'b0, 16'hDEAD);

        // reset lands on the edge where a write-back is pending
        step(1'b0, mk(4'h3, 3'd5, 3'd0, 5'h07), 1'b0, 16'h0);
        step(1'b1, nop, 1'b1, 16'hBEEF);
        step(1'b0, nop, 1'b0, 16'hBEEF);
        for (int i = 0; i < 8; i++) step(1'b0, mk(4'h2, 3'(i), 3'(i), 5'h00), 1'b0, 16'h0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 59) == 0, 15'($urandom), 1'($urandom), 16'($urandom));
        end
        for (int i = 0; i < 8; i++) step(1'b0, mk(4'h2, 3'(i), 3'(i), 5'h00), 1'b0, 16'h0);

        @(posedge CLK_EX);
        #3;
        chk("scoreboard_drained", 16'(sb.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
